// File: rtl/spwm_pkg.sv
// spwm_pkg: shared widths and the dead-time FSM state encoding for spwm_modulator.
package spwm_pkg;
    localparam int CARRIER_W = 8;
    localparam int SAMPLE_W = 8;
    localparam int DT_W = 8;
    typedef enum logic [2:0] {OFF, HI_ON, DT_TO_LO, LO_ON, DT_TO_HI} spwm_state_t;
endpackage

// File: rtl/spwm_modulator_if.sv
// spwm_if: bus between the sine-ROM address generator (master) and the modulator (slave).
//   master drives enable and sample; slave returns sample_req, period_start, gate_hi, gate_lo.
interface spwm_if;
    import spwm_pkg::*;
    logic enable;
    logic [SAMPLE_W-1:0] sample;
    logic sample_req;
    logic period_start;
    logic gate_hi;
    logic gate_lo;
    modport master (output enable, sample, input sample_req, period_start, gate_hi, gate_lo);
    modport slave (input enable, sample, output sample_req, period_start, gate_hi, gate_lo);
endinterface

// File: rtl/spwm_modulator_deadtime_gen.sv
// deadtime_gen: complementary gate pair from raw compare with DEADTIME cycles of both-off on each swap.
//   in: clk, rst (sync, active-high), enable, raw; out: gate_hi, gate_lo (registered).
module deadtime_gen
    import spwm_pkg::*;
#(
    parameter int DEADTIME = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic raw,
    output logic gate_hi,
    output logic gate_lo
);
    spwm_state_t state, nxt;
    logic [DT_W-1:0] dt_cnt;
    logic dt_done;
    assign dt_done = dt_cnt == DT_W'(DEADTIME - 1);
    // A raw reversal during dead time returns straight to the gate that never went off.
    always_comb begin
        nxt = OFF;
        case (state)
            OFF:      nxt = raw ? DT_TO_HI : DT_TO_LO;
            HI_ON:    nxt = raw ? HI_ON : DT_TO_LO;
            LO_ON:    nxt = raw ? DT_TO_HI : LO_ON;
            DT_TO_HI: nxt = !raw ? LO_ON : dt_done ? HI_ON : DT_TO_HI;
            DT_TO_LO: nxt = raw ? HI_ON : dt_done ? LO_ON : DT_TO_LO;
            default:  nxt = OFF;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= OFF;
            dt_cnt <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state <= nxt;
            dt_cnt <= (nxt == state && (state == DT_TO_HI || state == DT_TO_LO)) ? dt_cnt + 1'b1 : '0;
            gate_hi <= nxt == HI_ON;
            gate_lo <= nxt == LO_ON;
        end
    end
endmodule

// File: rtl/spwm_modulator.sv
// spwm_modulator: triangle-carrier sine PWM with one duty sample per period and a complementary gate pair.
//   in: clk, rst (sync, active-high); bus.enable, bus.sample
//   out: bus.sample_req, bus.period_start, bus.gate_hi, bus.gate_lo
//   SPWM_DEADTIME_EN defined: gates come from deadtime_gen; undefined: gates are registered raw / ~raw.
module spwm_modulator
    import spwm_pkg::*;
#(
    parameter int CARRIER_MAX = 255,
    parameter int DEADTIME = 8
) (
    input  logic clk,
    input  logic rst,
    spwm_if.slave bus
);
    if (CARRIER_MAX < 4 || CARRIER_MAX > 255) begin : g_bad_max
        $error("CARRIER_MAX out of range");
    end
    if (DEADTIME < 1 || DEADTIME > 255) begin : g_bad_dt
        $error("DEADTIME out of range");
    end
    logic [CARRIER_W-1:0] carrier;
    logic [SAMPLE_W-1:0] duty;
    logic up;
    logic raw;
    logic run;
    assign run = bus.enable && !rst;
    assign bus.period_start = run && carrier == '0;
    // Two cycles ahead of the valley: one for the address step, one for the ROM to settle.
    assign bus.sample_req = run && !up && carrier == CARRIER_W'(2);
    assign raw = duty > carrier;
    always_ff @(posedge clk) begin
        if (rst) begin
            carrier <= '0;
            up <= 1'b1;
            duty <= '0;
        end else if (!bus.enable) begin
            carrier <= '0;
            up <= 1'b1;
        end else begin
            if (carrier == '0)
                duty <= bus.sample;
            if (up) begin
                carrier <= carrier == CARRIER_W'(CARRIER_MAX) ? carrier - 1'b1 : carrier + 1'b1;
                up <= carrier != CARRIER_W'(CARRIER_MAX);
            end else begin
                carrier <= carrier == '0 ? CARRIER_W'(1) : carrier - 1'b1;
                up <= carrier == '0;
            end
        end
    end
`ifdef SPWM_DEADTIME_EN
    deadtime_gen #(.DEADTIME(DEADTIME)) u_dt (
        .clk(clk),
        .rst(rst),
        .enable(bus.enable),
        .raw(raw),
        .gate_hi(bus.gate_hi),
        .gate_lo(bus.gate_lo)
    );
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gate_hi <= 1'b0;
            bus.gate_lo <= 1'b0;
        end else begin
            bus.gate_hi <= bus.enable && raw;
            bus.gate_lo <= bus.enable && !raw;
        end
    end
`endif
endmodule

// File: tb/tb_spwm_modulator.sv
// tb_spwm_modulator: directed vector table plus hand sequences for spwm_modulator at 255/8 defaults.
module tb_spwm_modulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    spwm_if ifc();
    spwm_modulator #(.CARRIER_MAX(255), .DEADTIME(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] sample;
        int hi;
        int lo;
    } vec_t;
    vec_t vecs[6];
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask
    task automatic wait_sig(input bit want_req, output int n);
        n = 0;
        while (!(want_req ? ifc.sample_req : ifc.period_start)) begin
            tick();
            n++;
            if (n > 600) begin
                n = -1;
                return;
            end
        end
    endtask
    task automatic first_gate(output int n);
        n = 0;
        while (!(ifc.gate_hi || ifc.gate_lo) && n < 40) begin
            tick();
            n++;
        end
    endtask
    initial begin
        int hi, lo, both, req, ps, cmp, n, r1, bad;
`ifdef SPWM_DEADTIME_EN
        vecs[0] = '{8'd0, 0, 510};
        vecs[1] = '{8'd1, 0, 509};
        vecs[2] = '{8'd10, 11, 483};
        vecs[3] = '{8'd128, 247, 247};
        vecs[4] = '{8'd200, 391, 103};
        vecs[5] = '{8'd255, 509, 0};
`else
        vecs[0] = '{8'd0, 0, 510};
        vecs[1] = '{8'd1, 1, 509};
        vecs[2] = '{8'd10, 19, 491};
        vecs[3] = '{8'd128, 255, 255};
        vecs[4] = '{8'd200, 399, 111};
        vecs[5] = '{8'd255, 509, 1};
`endif
        ifc.enable = 1'b1;
        ifc.sample = 8'd77;
        repeat (3) tick();
        check("rst_gate_hi", ifc.gate_hi, 0);
        check("rst_gate_lo", ifc.gate_lo, 0);
        check("rst_req", ifc.sample_req, 0);
        check("rst_ps", ifc.period_start, 0);
        check("rst_carrier", dut.carrier, 0);
        rst = 1'b0;
        #1;
        check("first_valley_ps", ifc.period_start, 1);
        tick();
        check("first_duty", dut.duty, 77);
        check("first_carrier", dut.carrier, 1);
        foreach (vecs[i]) begin
            ifc.sample = vecs[i].sample;
            repeat (1020) tick();
            {hi, lo, both, req, ps, cmp} = '0;
            repeat (510) begin
                tick();
                hi += ifc.gate_hi;
                lo += ifc.gate_lo;
                both += ifc.gate_hi & ifc.gate_lo;
                req += ifc.sample_req;
                ps += ifc.period_start;
                cmp += ifc.gate_lo == ifc.gate_hi;
            end
            check($sformatf("hi_cycles[%0d]", vecs[i].sample), hi, vecs[i].hi);
            check($sformatf("lo_cycles[%0d]", vecs[i].sample), lo, vecs[i].lo);
            check($sformatf("overlap[%0d]", vecs[i].sample), both, 0);
            check($sformatf("req_per_period[%0d]", vecs[i].sample), req, 1);
            check($sformatf("ps_per_period[%0d]", vecs[i].sample), ps, 1);
`ifndef SPWM_DEADTIME_EN
            check($sformatf("lo_not_hi[%0d]", vecs[i].sample), cmp, 0);
`endif
        end
        ifc.sample = 8'd10;
        wait_sig(1'b0, n);
        check("wait_ps", n >= 0, 1);
        tick();
        check("duty_10", dut.duty, 10);
        wait_sig(1'b1, n);
        check("wait_req", n >= 0, 1);
        r1 = cyc;
        check("req_carrier", dut.carrier, 2);
        tick();
        ifc.sample = 8'd200;
        check("duty_before_valley", dut.duty, 10);
        tick();
        check("ps_two_after_req", ifc.period_start, 1);
        check("duty_at_valley", dut.duty, 10);
        tick();
        check("duty_200", dut.duty, 200);
        bad = 0;
        repeat (100) begin
            ifc.sample = 8'($urandom);
            tick();
            bad += dut.duty != 8'd200;
        end
        check("duty_hold_midperiod", bad, 0);
        ifc.sample = 8'd200;
        wait_sig(1'b1, n);
        check("req_interval", cyc - r1, 510);
        ifc.sample = 8'd0;
        repeat (1020) tick();
        ifc.enable = 1'b0;
        tick();
        check("dis_gate_lo", ifc.gate_lo, 0);
        check("dis_carrier", dut.carrier, 0);
        tick();
        ifc.enable = 1'b1;
        first_gate(n);
`ifdef SPWM_DEADTIME_EN
        check("zero_first_gate", n, 9);
`else
        check("zero_first_gate", n, 1);
`endif
        check("zero_gate_hi", ifc.gate_hi, 0);
        check("zero_gate_lo", ifc.gate_lo, 1);
        ifc.sample = 8'd128;
        repeat (1120) tick();
        ifc.enable = 1'b0;
        #1;
        check("dis_req", ifc.sample_req, 0);
        check("dis_ps", ifc.period_start, 0);
        tick();
        check("drop_gate_hi", ifc.gate_hi, 0);
        check("drop_gate_lo", ifc.gate_lo, 0);
        check("drop_carrier", dut.carrier, 0);
        check("drop_duty_held", dut.duty, 128);
        tick();
        ifc.enable = 1'b1;
        first_gate(n);
`ifdef SPWM_DEADTIME_EN
        check("reen_first_gate", n, 9);
`else
        check("reen_first_gate", n, 1);
`endif
        check("reen_gate_hi", ifc.gate_hi, 1);
        repeat (300) tick();
        rst = 1'b1;
        tick();
        check("midrst_gate_hi", ifc.gate_hi, 0);
        check("midrst_gate_lo", ifc.gate_lo, 0);
        check("midrst_carrier", dut.carrier, 0);
        check("midrst_duty", dut.duty, 0);
        rst = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spwm_modulator.md
# spwm_modulator

Sine-PWM gate generator, directly downstream of the sine lookup ROM.
- Runs a symmetric triangle carrier and latches one 8-bit ROM sample per carrier period as the duty value.
- Compares duty against the carrier and drives one complementary high/low gate pair with dead-time insertion.
- Emits a one-cycle `sample_req` strobe so the upstream address generator advances the ROM address in time for the next period.

## Interface
- `CARRIER_MAX`, 255: carrier peak; legal 4..255; carrier width 8 bits.
- `DEADTIME`, 8: dead-time in clk cycles; legal 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run modulator; low forces both gates off.
- `sample`  in  8  unsigned ROM data (asynchronous ROM output, stable one cycle after its address changes).
- `sample_req`  out  1  one-cycle pulse: upstream advances address.
- `period_start`  out  1  one-cycle pulse on the cycle the duty register loads.
- `gate_hi`  out  1  high-side gate, active-high.
- `gate_lo`  out  1  low-side gate, active-high.

## Operation
- **Carrier:**
  - Up/down counter 0→CARRIER_MAX→1→0…, giving a period of 2·CARRIER_MAX cycles.
  - Direction flips at 0 (to up) and CARRIER_MAX (to down).
- **Duty:**
  - `duty` loads `sample` on every valley cycle (carrier==0, enabled); `period_start`=1 that cycle.
  - `sample` is ignored on all other cycles.
- **Request:** `sample_req`=1 on the cycle carrier==2 while counting down, i.e. two cycles before the valley.
- **Raw compare:** `raw` = (duty > carrier), unsigned and combinational from registered values.
  - duty=0 gives raw never high.
  - duty>CARRIER_MAX gives raw always high.
- **Dead-time FSM** (per gate pair): states OFF, HI_ON, DT_TO_LO, LO_ON, DT_TO_HI; dead-time counter `dt_cnt`.
  - OFF: both gates 0. On enable, go to DT_TO_HI if raw, else DT_TO_LO, with dt_cnt=0.
  - HI_ON (gate_hi=1): raw=0 → DT_TO_LO, dt_cnt=0.
  - LO_ON (gate_lo=1): raw=1 → DT_TO_HI, dt_cnt=0.
  - DT_TO_x (both gates 0): dt_cnt increments; at dt_cnt==DEADTIME-1, go to x_ON.
  - DT_TO_HI with raw back to 0 → LO_ON immediately. DT_TO_LO with raw back to 1 → HI_ON immediately. No dead time applies, since the target gate never turned on.
  - gate_hi and gate_lo are never 1 in the same cycle.
- **Enable low:**
  - Next edge: state OFF, carrier=0, direction up, gates 0.
  - `duty` holds its value; `sample_req`/`period_start` are suppressed.
  - The first enabled cycle is a valley, so duty loads.

## Timing
- **Reset:** every output = 0, carrier = 0, direction = up, duty = 0, state = OFF, dt_cnt = 0.
- **Reset mid-operation:** same reset state at the next edge; gates drop within one cycle.
- **Gate latency (all gate outputs are registered):**
  - A raw change at cycle t turns off the active gate at edge t+1.
  - The opposite gate turns on at edge t+1+DEADTIME.
- **Sample path:**
  - Upstream advances its address on the edge after `sample_req`.
  - The ROM settles during the following cycle, and duty latches at the valley edge.
- **Minimum on-time:** a raw pulse shorter than DEADTIME cycles never turns on the opposite gate.

## Configuration
- Macro: `SPWM_DEADTIME_EN`.
- **Defined:** FSM and dead-time counter exactly as above.
- **Undefined:**
  - FSM and counter are omitted; `DEADTIME` is ignored.
  - gate_hi = registered raw and gate_lo = registered ~raw while enabled, with 1-cycle latency.
  - Both gates are 0 when disabled or in reset.

## Structure
- **Package `spwm_pkg`:** FSM state enum `spwm_state_t`; `CARRIER_W`=8; `SAMPLE_W`=8; `DT_W`=8.
- **Sub-module `deadtime_gen`:** FSM plus dt_cnt; inputs clk, rst, enable, raw; outputs gate_hi, gate_lo.
  - Instantiated only under `SPWM_DEADTIME_EN`.
  - The top holds the carrier, duty, request and compare.

## Test plan
All scenarios use defaults: CARRIER_MAX=255, DEADTIME=8.
- **Reset:** rst=1 for 3 cycles with enable=1 → all outputs 0 and carrier 0. Deassert → first valley loads duty.
- **Zero duty:** sample=0, enable → gate_hi never 1; gate_lo=1 from 9 cycles after enable, constant thereafter.
- **Half duty:** sample=128 → raw high 255 of 510 cycles; gate_hi high 247 cycles and gate_lo high 247 cycles per period; never both high.
- **Request:**
  - `sample_req` every 510 cycles, 2 cycles before `period_start`.
  - Model steps sample 10→200 on req → duty changes only at the following valley.
  - Toggling sample mid-period has no effect.
- **Short pulse:** sample=1 → raw high one cycle per period at the valley; gate_lo low exactly 1 cycle, gate_hi never 1.
- **Enable drop:** enable=0 mid-period → gates 0 next cycle, carrier 0. Re-enable → 8 cycles both-low before either gate asserts.
- **Macro undefined:** sample=128 → gate_lo == ~gate_hi every enabled cycle, gate_hi high 255 cycles per period.
